// File: rtl/mux_nch_scan.sv
// mux_nch_scan: registered NCH-channel, W-bit mux with a single output slot.
//   Latency: one cycle from capture decision to out_valid; DIRECT (host sel/req) or SCAN (round-robin, DWELL spacing).
//   Backpressure: slot holds while out_valid & !out_ready; req_ready drops and the scanner stalls without skipping a channel.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_data[NCH*W]          packed channels, channel k = in_data[k*W +: W]
//   mode                    0 = DIRECT, 1 = SCAN
//   sel, req, req_ready     DIRECT-mode select, capture request, slot-free indication
//   out_data, out_ch,       captured data, its channel index, out-of-range flag
//   out_err
//   out_valid, out_ready    output slot handshake
module mux_nch_scan #(
  parameter  int NCH   = 16,
  parameter  int W     = 8,
  parameter  int DWELL = 1,
  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*W-1:0]  in_data,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic              req,
  output logic              req_ready,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [7:0]      CNT_LAST = 8'(DWELL - 1);
  localparam logic [SELW-1:0] POS_LAST = SELW'(NCH - 1);
  localparam logic [SELW:0]   NCH_V    = (SELW + 1)'(NCH);

  logic [SELW-1:0] scan_pos, scan_pos_nxt, pos_eff;
  logic [7:0]      dwell_cnt, dwell_nxt, cnt_eff;
  logic            mode_q;

  logic            free;
  logic            mode_rise;
  logic            sel_ok;
  logic            dwell_done;
  logic            direct_cap, scan_cap, cap;
  logic [W-1:0]    sel_dat, scan_dat, cap_dat;
  logic [SELW-1:0] cap_ch;
  logic            cap_err;

  assign free      = !out_valid | out_ready;
  assign req_ready = free & !mode;
  assign mode_rise = mode & !mode_q;

  // On the first SCAN cycle the scanner behaves as if freshly restarted, so
  // the first sample lands DWELL cycles after the mode rise.
  assign pos_eff    = mode_rise ? '0 : scan_pos;
  assign cnt_eff    = mode_rise ? '0 : dwell_cnt;
  assign dwell_done = (cnt_eff == CNT_LAST);

  assign sel_ok     = ({1'b0, sel} < NCH_V);
  assign direct_cap = req & req_ready;
  assign scan_cap   = mode & dwell_done & free;
  assign cap        = direct_cap | scan_cap;

  // Compare-and-select muxes keep every index in range, including
  // non-power-of-two NCH where sel can name a channel that does not exist.
  always_comb begin
    sel_dat  = '0;
    scan_dat = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k))     sel_dat  = in_data[k*W +: W];
      if (pos_eff == SELW'(k)) scan_dat = in_data[k*W +: W];
    end
  end

  always_comb begin
    cap_dat = '0;
    cap_ch  = sel;
    cap_err = 1'b0;
    if (mode) begin
      cap_dat = scan_dat;
      cap_ch  = pos_eff;
    end else begin
      cap_dat = sel_ok ? sel_dat : '0;
      cap_err = !sel_ok;
    end
  end

  always_comb begin
    scan_pos_nxt = scan_pos;
    dwell_nxt    = dwell_cnt;
    if (mode) begin
      if (dwell_done) begin
        if (free) begin
          scan_pos_nxt = (pos_eff == POS_LAST) ? '0 : SELW'(pos_eff + 1'b1);
          dwell_nxt    = '0;
        end else begin
          // Stall: hold the due channel until the slot frees.
          scan_pos_nxt = pos_eff;
          dwell_nxt    = cnt_eff;
        end
      end else begin
        scan_pos_nxt = pos_eff;
        dwell_nxt    = 8'(cnt_eff + 8'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      scan_pos  <= '0;
      dwell_cnt <= '0;
      mode_q    <= 1'b0;
    end else begin
      mode_q    <= mode;
      scan_pos  <= scan_pos_nxt;
      dwell_cnt <= dwell_nxt;
      if (cap) begin
        out_data  <= cap_dat;
        out_ch    <= cap_ch;
        out_err   <= cap_err;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nch_scan.sv
module tb_mux_nch_scan;

  typedef struct packed {
    logic [3:0] ch;
    logic [7:0] dat;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: NCH=16, DWELL=1
  logic [127:0] in_a;
  logic         mode_a, req_a, req_ready_a, out_err_a, out_valid_a, out_ready_a;
  logic [3:0]   sel_a, out_ch_a;
  logic [7:0]   out_data_a;

  // DUT B: NCH=12, DWELL=3
  logic [95:0]  in_b;
  logic         mode_b, req_b, req_ready_b, out_err_b, out_valid_b, out_ready_b;
  logic [3:0]   sel_b, out_ch_b;
  logic [7:0]   out_data_b;

  mux_nch_scan #(.NCH(16), .W(8), .DWELL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_a), .mode(mode_a), .sel(sel_a),
    .req(req_a), .req_ready(req_ready_a), .out_data(out_data_a), .out_ch(out_ch_a),
    .out_err(out_err_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
  );

  mux_nch_scan #(.NCH(12), .W(8), .DWELL(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_b), .mode(mode_b), .sel(sel_b),
    .req(req_b), .req_ready(req_ready_b), .out_data(out_data_b), .out_ch(out_ch_b),
    .out_err(out_err_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t e;

  task automatic test_reset;
    rst_n = 1'b0;
    mode_a = 1'($urandom); sel_a = 4'($urandom); req_a = 1'($urandom); out_ready_a = 1'($urandom);
    mode_b = 1'($urandom); sel_b = 4'($urandom); req_b = 1'($urandom); out_ready_b = 1'($urandom);
    repeat (3) @(negedge clk);
    total++;
    if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
      bad++; $display("FAIL reset_hold got valid a=%b b=%b exp 0", out_valid_a, out_valid_b);
    end
    mode_a = 0; req_a = 0; out_ready_a = 0; sel_a = 0;
    mode_b = 0; req_b = 0; out_ready_b = 0; sel_b = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      total++;
      if (out_valid_a !== 1'b0) begin bad++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", i, out_valid_a); end
      total++;
      if (out_data_a !== 8'h00) begin bad++; $display("FAIL idle_data cyc=%0d got=%h exp=00", i, out_data_a); end
      total++;
      if (req_ready_a !== 1'b1) begin bad++; $display("FAIL idle_req_ready cyc=%0d got=%b exp=1", i, req_ready_a); end
      total++;
      if (out_valid_b !== 1'b0) begin bad++; $display("FAIL idle_valid_b cyc=%0d got=%b exp=0", i, out_valid_b); end
    end
  endtask

  task automatic test_direct_basic;
    q.delete();
    @(negedge clk);
    sel_a = 4'd5; req_a = 1'b1; out_ready_a = 1'b1;
    q.push_back('{ch: 4'd5, dat: 8'hA5, err: 1'b0});
    #1;
    total++;
    if (req_ready_a !== 1'b1) begin bad++; $display("FAIL direct_req_ready got=%b exp=1", req_ready_a); end
    @(negedge clk);
    req_a = 1'b0; #1;
    total++;
    if (out_valid_a !== 1'b1) begin bad++; $display("FAIL direct_latency got valid=%b exp=1", out_valid_a); end
    if (out_valid_a && out_ready_a) begin
      total++;
      if (q.size() == 0) begin bad++; $display("FAIL direct_extra got ch=%0d exp=none", out_ch_a); end
      else begin
        e = q.pop_front();
        if ({out_ch_a, out_data_a, out_err_a} !== {e.ch, e.dat, e.err}) begin
          bad++; $display("FAIL direct_data got ch=%0d d=%h err=%b exp ch=%0d d=%h err=%b",
                          out_ch_a, out_data_a, out_err_a, e.ch, e.dat, e.err);
        end
      end
    end
    @(negedge clk); #1;
    total++;
    if (out_valid_a !== 1'b0 || q.size() != 0) begin
      bad++; $display("FAIL direct_drop got valid=%b pending=%0d exp valid=0 pending=0", out_valid_a, q.size());
    end
  endtask

  task automatic test_backpressure;
    q.delete();
    @(negedge clk);
    out_ready_a = 1'b0; sel_a = 4'd3; req_a = 1'b1;
    q.push_back('{ch: 4'd3, dat: 8'hA3, err: 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sel_a = 4'd9; req_a = 1'b1; #1;
      total++;
      if (out_valid_a !== 1'b1 || out_ch_a !== 4'd3 || out_data_a !== 8'hA3) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b ch=%0d d=%h exp v=1 ch=3 d=a3", i, out_valid_a, out_ch_a, out_data_a);
      end
      total++;
      if (req_ready_a !== 1'b0) begin bad++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=0", i, req_ready_a); end
    end
    // Release: same edge consumes channel 3 and loads channel 9.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready_a = 1'b1;
      if (i == 0) q.push_back('{ch: 4'd9, dat: 8'hA9, err: 1'b0});
      if (i == 1) req_a = 1'b0;
      #1;
      if (i < 2) begin
        total++;
        if (out_valid_a !== 1'b1) begin bad++; $display("FAIL bp_no_bubble cyc=%0d got valid=%b exp=1", i, out_valid_a); end
      end
      if (out_valid_a && out_ready_a) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL bp_extra got ch=%0d exp=none", out_ch_a); end
        else begin
          e = q.pop_front();
          if ({out_ch_a, out_data_a, out_err_a} !== {e.ch, e.dat, e.err}) begin
            bad++; $display("FAIL bp_data got ch=%0d d=%h err=%b exp ch=%0d d=%h err=%b",
                            out_ch_a, out_data_a, out_err_a, e.ch, e.dat, e.err);
          end
        end
      end
    end
    total++;
    if (out_valid_a !== 1'b0 || q.size() != 0) begin
      bad++; $display("FAIL bp_drain got valid=%b pending=%0d exp valid=0 pending=0", out_valid_a, q.size());
    end
  endtask

  task automatic test_scan_wrap;
    q.delete();
    @(negedge clk);
    out_ready_a = 1'b1; req_a = 1'b0; mode_a = 1'b1;
    for (int k = 0; k < 17; k++) q.push_back('{ch: 4'(k % 16), dat: 8'(8'hA0 + (k % 16)), err: 1'b0});
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 17) mode_a = 1'b0;
      #1;
      total++;
      if (out_valid_a !== 1'b1) begin bad++; $display("FAIL wrap_rate cyc=%0d got valid=%b exp=1", i, out_valid_a); end
      if (out_valid_a && out_ready_a) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL wrap_extra got ch=%0d exp=none", out_ch_a); end
        else begin
          e = q.pop_front();
          if ({out_ch_a, out_data_a, out_err_a} !== {e.ch, e.dat, e.err}) begin
            bad++; $display("FAIL wrap_data got ch=%0d d=%h err=%b exp ch=%0d d=%h err=%b",
                            out_ch_a, out_data_a, out_err_a, e.ch, e.dat, e.err);
          end
        end
      end
    end
    @(negedge clk); #1;
    total++;
    if (out_valid_a !== 1'b0 || q.size() != 0) begin
      bad++; $display("FAIL wrap_stop got valid=%b pending=%0d exp valid=0 pending=0", out_valid_a, q.size());
    end
  endtask

  task automatic test_scan_dwell_stall;
    int cyc, last_t, stall_left;
    logic stall_done;
    logic [3:0] last_ch;
    q.delete();
    cyc = 0; last_t = 0; stall_left = 0; stall_done = 1'b0; last_ch = 4'hF;
    for (int k = 0; k < 8; k++) q.push_back('{ch: 4'(k), dat: 8'(8'h50 + k), err: 1'b0});
    @(negedge clk);
    out_ready_b = 1'b1; req_b = 1'b0; mode_b = 1'b1;
    while (q.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!stall_done && out_valid_b && out_ch_b == 4'd4) begin
        stall_left = 5; stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        out_ready_b = 1'b0;
        stall_left--;
        total++;
        if (out_valid_b !== 1'b1 || out_ch_b !== 4'd4 || out_data_b !== 8'h54) begin
          bad++; $display("FAIL stall_hold cyc=%0d got v=%b ch=%0d d=%h exp v=1 ch=4 d=54", cyc, out_valid_b, out_ch_b, out_data_b);
        end
      end else begin
        out_ready_b = 1'b1;
      end
      #1;
      if (out_valid_b && out_ch_b !== last_ch) begin
        total++;
        if (cyc - last_t != ((out_ch_b == 4'd5) ? 6 : 3)) begin
          bad++; $display("FAIL dwell_spacing ch=%0d got=%0d exp=%0d", out_ch_b, cyc - last_t, (out_ch_b == 4'd5) ? 6 : 3);
        end
        last_ch = out_ch_b; last_t = cyc;
      end
      if (out_valid_b && out_ready_b) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL dwell_extra got ch=%0d exp=none", out_ch_b); end
        else begin
          e = q.pop_front();
          if ({out_ch_b, out_data_b, out_err_b} !== {e.ch, e.dat, e.err}) begin
            bad++; $display("FAIL dwell_data got ch=%0d d=%h err=%b exp ch=%0d d=%h err=%b",
                            out_ch_b, out_data_b, out_err_b, e.ch, e.dat, e.err);
          end
        end
      end
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL dwell_timeout got pending=%0d exp=0", q.size()); end
    @(negedge clk);
    mode_b = 1'b0; out_ready_b = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_out_of_range;
    q.delete();
    @(negedge clk);
    mode_b = 1'b0; out_ready_b = 1'b1; sel_b = 4'd13; req_b = 1'b1;
    q.push_back('{ch: 4'd13, dat: 8'h00, err: 1'b1});
    #1;
    total++;
    if (req_ready_b !== 1'b1) begin bad++; $display("FAIL oor_req_ready got=%b exp=1", req_ready_b); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) begin
        sel_b = 4'd11;
        q.push_back('{ch: 4'd11, dat: 8'h5B, err: 1'b0});
      end else begin
        req_b = 1'b0;
      end
      #1;
      total++;
      if (!(out_valid_b && out_ready_b) || q.size() == 0) begin
        bad++; $display("FAIL oor_missing cyc=%0d got valid=%b exp=1", i, out_valid_b);
      end else begin
        e = q.pop_front();
        if ({out_ch_b, out_data_b, out_err_b} !== {e.ch, e.dat, e.err}) begin
          bad++; $display("FAIL oor_data got ch=%0d d=%h err=%b exp ch=%0d d=%h err=%b",
                          out_ch_b, out_data_b, out_err_b, e.ch, e.dat, e.err);
        end
      end
    end
    @(negedge clk); #1;
    total++;
    if (out_valid_b !== 1'b0) begin bad++; $display("FAIL oor_drop got valid=%b exp=0", out_valid_b); end
  endtask

  task automatic test_reset_mid_scan;
    int n;
    logic seen;
    @(negedge clk);
    mode_b = 1'b1; out_ready_b = 1'b1; req_b = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk); #1;
      n++;
      if (out_valid_b && out_ch_b == 4'd6) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rst_mid_reach got seen=0 exp=1"); end
    // scan_pos is now 7; reset lands mid-cycle, away from any edge.
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid_b !== 1'b0 || out_data_b !== 8'h00 || out_ch_b !== 4'd0 || out_err_b !== 1'b0) begin
      bad++; $display("FAIL rst_mid_clear got v=%b d=%h ch=%0d err=%b exp all 0", out_valid_b, out_data_b, out_ch_b, out_err_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk); #1;
      n++;
      if (out_valid_b) seen = 1'b1;
    end
    total++;
    if (!seen || n != 3) begin bad++; $display("FAIL rst_mid_first_time got cyc=%0d exp=3", n); end
    total++;
    if (out_ch_b !== 4'd0 || out_data_b !== 8'h50) begin
      bad++; $display("FAIL rst_mid_first_ch got ch=%0d d=%h exp ch=0 d=50", out_ch_b, out_data_b);
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) in_a[k*8 +: 8] = 8'(8'hA0 + k);
    for (int k = 0; k < 12; k++) in_b[k*8 +: 8] = 8'(8'h50 + k);
    test_reset();
    test_direct_basic();
    test_backpressure();
    test_scan_wrap();
    test_scan_dwell_stall();
    test_out_of_range();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_nch_scan.md
Name: mux_nch_scan

Overview:
Registered N-channel, W-bit multiplexer. It generalises the 16:1 single-bit combinational mux to any channel count and data width. It adds two modes: host-selected capture (DIRECT) and an autonomous round-robin channel scanner (SCAN). Output is a single registered slot with a valid/ready handshake. The block sits between a bank of sensor/data lanes and a single downstream consumer.

Parameters:
NCH, 16, number of input channels (2..256; non-power-of-two allowed)
W, 8, data width per channel (1..64)
DWELL, 1, cycles between successive SCAN-mode samples (1..255)
SELW (localparam), clog2(NCH), select/channel index width

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  NCH*W  packed channels; channel k = in_data[k*W +: W]
mode  input  1  0 = DIRECT, 1 = SCAN
sel  input  SELW  DIRECT-mode channel select
req  input  1  DIRECT-mode capture request
req_ready  output  1  slot can accept a capture this cycle
out_data  output  W  captured channel data
out_ch  output  SELW  channel index of out_data
out_err  output  1  captured select was out of range (sel >= NCH)
out_valid  output  1  slot holds data
out_ready  input  1  consumer accepts slot

Behaviour:
- Reset (async assert, sync release): out_data=0, out_ch=0, out_err=0, out_valid=0, scan_pos=0, dwell_cnt=0, mode_q=0.
- Slot free: free = !out_valid | out_ready. Combinationally, req_ready = free & !mode.
- Capture loads out_data, out_ch and out_err and sets out_valid at the next edge, so latency is 1 cycle.
- On a handshake (out_valid & out_ready) with no capture in the same cycle, out_valid clears.
- On a handshake with a capture in the same cycle, the slot reloads and out_valid stays 1. There is no bubble.
- While out_valid=1 and out_ready=0, out_data, out_ch and out_err are held stable.
- DIRECT (mode=0): a capture fires when req & req_ready.
  - Captured data is in_data[sel], out_ch=sel, out_err=0.
  - If sel >= NCH: out_data=0, out_ch=sel, out_err=1, out_valid=1. Out-of-range is reported, never dropped.
  - req while !req_ready is ignored. There is no queueing; the requester must hold req.
- SCAN (mode=1): req and sel are ignored.
  - dwell_cnt counts 0..DWELL-1.
  - When dwell_cnt==DWELL-1 and free: capture in_data[scan_pos], out_ch=scan_pos, out_err=0. Then scan_pos advances (NCH-1 wraps to 0) and dwell_cnt resets to 0.
  - When dwell_cnt==DWELL-1 and !free: dwell_cnt holds and scan_pos holds (stall). No channel is skipped.
  - With DWELL=1 and out_ready tied high, one sample is produced per cycle in order 0,1,..,NCH-1,0,...
- Mode switching: mode is registered as mode_q to detect edges.
  - A 0->1 transition sets scan_pos=0 and dwell_cnt=0. The first SCAN capture then occurs DWELL cycles after the mode rise, if the slot is free.
  - A 1->0 transition stops scanning immediately. DIRECT captures are allowed in the same cycle mode reads 0.
  - Slot contents survive any mode change.
- Reset mid-operation: all state clears asynchronously and any pending slot data is discarded. After release, the next SCAN sample is channel 0.

Test Plan:
- Reset/idle: hold rst_n=0 with random inputs, then release, mode=0, req=0 -> out_valid=0, out_data=0, req_ready=1 for 10 cycles.
- DIRECT basic (NCH=16, W=8): in_data channel k = 8'hA0+k, sel=5, req=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_ch=5, out_err=0; valid drops after 1 cycle.
- Backpressure: out_ready=0, capture sel=3, then req with sel=9 for 4 cycles -> out_data stays channel 3 and req_ready=0. Raise out_ready -> the same edge loads channel 9 with out_valid held at 1.
- SCAN wrap (DWELL=1, out_ready=1): mode 0->1 -> samples appear starting 1 cycle later in out_ch order 0..15 then 0, one per cycle, data matching each channel.
- SCAN dwell+stall (DWELL=3): samples 3 cycles apart. Deassert out_ready for 5 cycles at channel 4 -> channel 4 held, next emitted out_ch=5, no skip.
- Out-of-range (NCH=12): DIRECT sel=13 -> out_err=1, out_data=0, out_ch=13. Assert rst_n=0 mid-SCAN at scan_pos=7 -> outputs clear immediately; after release in SCAN the first out_ch=0.
